// File: rtl/cpu_boot_seq.sv
// Boot sequencer for the embedded stack CPU: stages host code words in a small FIFO,
// streams them into code BRAM as one LOAD burst, then hands the CPU over to RUN.
module cpu_boot_seq #(
  parameter int CODE_WORDS = 1024,
  parameter int DEPTH      = 16,
  parameter int PREFILL    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_start,
  input  logic        host_halt,
  input  logic [15:0] host_wdata,
  input  logic        host_wvalid,
  output logic        host_wready,
  input  logic [15:0] rd_par,
  output logic [1:0]  cpu_rst,
  output logic [15:0] cpu_par,
  output logic        boot_done,
  output logic        busy,
  output logic        err,
  output logic [10:0] word_cnt
);

  localparam int          AW = $clog2(DEPTH);
  localparam logic [10:0] CW = 11'(CODE_WORDS);
  localparam logic [AW:0] PF = (AW+1)'(PREFILL);
  localparam logic [AW:0] DP = (AW+1)'(DEPTH);

  localparam logic [1:0] RST_OFF  = 2'b00;
  localparam logic [1:0] RST_LOAD = 2'b01;
  localparam logic [1:0] RST_RUN  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LOAD,
    S_SYNC,
    S_RUN,
    S_ERR
  } state_t;

  state_t      state, state_nx;

  logic [15:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] level, level_nx;
  logic [10:0] push_cnt, push_cnt_nx;
  logic [10:0] word_cnt_nx;
  logic        full, empty, flush, push, pop;
  logic        err_nx, wready_nx, boot_done_nx, busy_nx;
  logic [1:0]  cpu_rst_nx;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == DP);
  assign empty = (level == '0);
  assign flush = host_start || host_halt;

  assign push = host_wvalid && host_wready && !full && (push_cnt < CW) && !flush;
  assign pop  = (state == S_LOAD) && !empty;

  assign level_nx    = flush ? '0 : level + (AW+1)'(push) - (AW+1)'(pop);
  assign push_cnt_nx = flush ? '0 : push_cnt + 11'(push);

  // Boot data reaches the CPU only while LOAD is asserted.
  assign cpu_par = cpu_rst[0] ? mem[rd_ptr[AW-1:0]] : rd_par;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_nx    = state;
    err_nx      = err;
    word_cnt_nx = word_cnt;

    if (pop && (word_cnt < CW)) word_cnt_nx = word_cnt + 11'd1;

    case (state)
      S_IDLE: ;
      S_FILL: if ((level_nx >= PF) || (push_cnt_nx == CW)) state_nx = S_LOAD;
      // Underrun is caught on the edge the FIFO drains, so LOAD never spans an empty cycle.
      S_LOAD: begin
        if (word_cnt_nx == CW) begin
          state_nx = S_SYNC;
        end else if (level_nx == '0) begin
          state_nx = S_ERR;
          err_nx   = 1'b1;
        end
      end
      S_SYNC: state_nx = S_RUN;
      S_RUN:  ;
      S_ERR:  ;
      default: state_nx = S_IDLE;
    endcase

    if (host_halt) begin
      state_nx = S_IDLE;
    end else if (host_start) begin
      state_nx    = S_FILL;
      err_nx      = 1'b0;
      word_cnt_nx = '0;
    end

    wready_nx    = ((state_nx == S_FILL) || (state_nx == S_LOAD)) &&
                   (level_nx < DP) && (push_cnt_nx < CW);
    boot_done_nx = (state_nx == S_SYNC);
    busy_nx      = (state_nx == S_FILL) || (state_nx == S_LOAD) || (state_nx == S_SYNC);

    case (state_nx)
      S_LOAD:       cpu_rst_nx = RST_LOAD;
      S_SYNC, S_RUN: cpu_rst_nx = RST_RUN;
      default:      cpu_rst_nx = RST_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      push_cnt    <= '0;
      word_cnt    <= '0;
      err         <= 1'b0;
      host_wready <= 1'b0;
      cpu_rst     <= RST_OFF;
      boot_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state       <= state_nx;
      push_cnt    <= push_cnt_nx;
      word_cnt    <= word_cnt_nx;
      err         <= err_nx;
      host_wready <= wready_nx;
      cpu_rst     <= cpu_rst_nx;
      boot_done   <= boot_done_nx;
      busy        <= busy_nx;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= host_wdata;
  end

endmodule

// File: tb/tb_cpu_boot_seq.sv
// Scoreboard bench for cpu_boot_seq: two instances (a small-FIFO boot and a short boot
// below the prefill level), random code words and host gaps, timing predicted from timestamps.
module tb_cpu_boot_seq;

  localparam int CW0 = 8;
  localparam int DP0 = 4;
  localparam int PF0 = 4;
  localparam int CW1 = 3;
  localparam int DP1 = 16;
  localparam int PF1 = 12;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        start, halt, wvalid;
  logic [1:0][15:0]  wdata;
  logic [1:0][15:0]  rd_par = '0;

  wire  [1:0]        wready, boot_done, busy, err;
  wire  [1:0][1:0]   cpu_rst;
  wire  [1:0][15:0]  cpu_par;
  wire  [1:0][10:0]  word_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] exp_q   [2][$];
  int          acc_cyc [2][$];
  int          acc_n     [2];
  int          load_cnt  [2];
  int          sync_cnt  [2];
  bit          booting   [2];
  bit          prev_load [2];

  cpu_boot_seq #(.CODE_WORDS(CW0), .DEPTH(DP0), .PREFILL(PF0)) u_a (
    .clk(clk), .rst_n(rst_n), .host_start(start[0]), .host_halt(halt[0]),
    .host_wdata(wdata[0]), .host_wvalid(wvalid[0]), .host_wready(wready[0]),
    .rd_par(rd_par[0]), .cpu_rst(cpu_rst[0]), .cpu_par(cpu_par[0]),
    .boot_done(boot_done[0]), .busy(busy[0]), .err(err[0]), .word_cnt(word_cnt[0])
  );

  cpu_boot_seq #(.CODE_WORDS(CW1), .DEPTH(DP1), .PREFILL(PF1)) u_b (
    .clk(clk), .rst_n(rst_n), .host_start(start[1]), .host_halt(halt[1]),
    .host_wdata(wdata[1]), .host_wvalid(wvalid[1]), .host_wready(wready[1]),
    .rd_par(rd_par[1]), .cpu_rst(cpu_rst[1]), .cpu_par(cpu_par[1]),
    .boot_done(boot_done[1]), .busy(busy[1]), .err(err[1]), .word_cnt(word_cnt[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    rd_par[0] = 16'($urandom);
    rd_par[1] = 16'($urandom);
  end

  function automatic int cw_of(input int u); return (u == 0) ? CW0 : CW1; endfunction
  function automatic int dp_of(input int u); return (u == 0) ? DP0 : DP1; endfunction
  function automatic int pf_of(input int u); return (u == 0) ? PF0 : PF1; endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // LOAD ends early at the first word that had not arrived by the cycle it is due.
  function automatic int predict(input int u);
    int first = (pf_of(u) < cw_of(u)) ? pf_of(u) : cw_of(u);
    int p;
    if (acc_n[u] < first) return 0;
    p = acc_cyc[u][first-1];
    for (int j = first; j < cw_of(u); j++)
      if (j >= acc_n[u] || acc_cyc[u][j] > p + j) return j;
    return cw_of(u);
  endfunction

  // Monitor: pops the expected word on every LOAD cycle, checks the par mux otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int u = 0; u < 2; u++) begin
        if (booting[u] && (acc_n[u] - load_cnt[u]) >= dp_of(u))
          check("wready_when_full", wready[u], 0);
        if (cpu_rst[u] == 2'b01) begin
          if (load_cnt[u] > 0) check("load_contiguous", prev_load[u], 1);
          check("load_has_word", exp_q[u].size() > 0, 1);
          if (exp_q[u].size() > 0) check("load_data", cpu_par[u], exp_q[u].pop_front());
          check("load_addr", word_cnt[u], load_cnt[u]);
          load_cnt[u]++;
        end else begin
          check("par_mux", cpu_par[u], rd_par[u]);
        end
        if (boot_done[u]) begin
          check("sync_rst", cpu_rst[u], 2'b10);
          check("sync_cnt", word_cnt[u], cw_of(u));
          sync_cnt[u]++;
        end
        prev_load[u] = (cpu_rst[u] == 2'b01);
      end
    end
  end

  task automatic pulse(input int u, input bit do_start, input bit do_halt);
    start[u] = do_start;
    halt[u]  = do_halt;
    @(posedge clk); #1;
    start[u] = 1'b0;
    halt[u]  = 1'b0;
  endtask

  task automatic begin_boot(input int u);
    exp_q[u].delete();
    acc_cyc[u].delete();
    acc_n[u]    = 0;
    load_cnt[u] = 0;
    sync_cnt[u] = 0;
    booting[u]  = 1'b1;
    pulse(u, 1'b1, 1'b0);
  endtask

  task automatic push_word(input int u, input logic [15:0] data, output bit ok);
    bit rdy;
    ok        = 1'b0;
    wvalid[u] = 1'b1;
    wdata[u]  = data;
    for (int t = 0; t < 16 && !ok; t++) begin
      @(negedge clk);
      rdy = wready[u];
      @(posedge clk); #1;
      if (rdy) ok = 1'b1;
    end
    wvalid[u] = 1'b0;
    if (ok) begin
      exp_q[u].push_back(data);
      acc_cyc[u].push_back(cyc);
      acc_n[u]++;
    end
  endtask

  task automatic run_boot(input int u, input int gap_max, input int n_words);
    bit ok;
    int t;
    int exp_loads;
    begin_boot(u);
    ok = 1'b1;
    for (int j = 0; j < n_words && ok; j++) begin
      repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
      push_word(u, 16'($urandom), ok);
    end
    if (ok && n_words == cw_of(u)) begin
      @(negedge clk);
      check("no_extra_accept", wready[u], 0);
    end
    t = 0;
    while (sync_cnt[u] == 0 && err[u] !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("boot_ends", t < 60, 1);
    repeat (2) @(negedge clk);
    exp_loads = predict(u);
    check("load_cycles", load_cnt[u], exp_loads);
    check("words_left", exp_q[u].size(), acc_n[u] - exp_loads);
    if (exp_loads == cw_of(u)) begin
      check("sync_pulses", sync_cnt[u], 1);
      check("run_rst", cpu_rst[u], 2'b10);
      check("run_done_low", boot_done[u], 0);
      check("run_err", err[u], 0);
      check("run_busy", busy[u], 0);
      check("run_wready", wready[u], 0);
    end else begin
      check("err_flag", err[u], 1);
      check("err_rst", cpu_rst[u], 2'b00);
      check("err_cnt", word_cnt[u], exp_loads);
      check("err_no_sync", sync_cnt[u], 0);
    end
    booting[u] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input int u, input logic [10:0] cnt, input bit e);
    @(negedge clk);
    check("idle_rst", cpu_rst[u], 2'b00);
    check("idle_done", boot_done[u], 0);
    check("idle_busy", busy[u], 0);
    check("idle_wready", wready[u], 0);
    check("idle_cnt", word_cnt[u], cnt);
    check("idle_err", err[u], e);
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input int u);
    check("rst_cpu_rst", cpu_rst[u], 2'b00);
    check("rst_done", boot_done[u], 0);
    check("rst_wready", wready[u], 0);
    check("rst_busy", busy[u], 0);
    check("rst_err", err[u], 0);
    check("rst_cnt", word_cnt[u], 0);
    check("rst_par", cpu_par[u], rd_par[u]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    start  = '0;
    halt   = '0;
    wvalid = '0;
    wdata  = '0;
    for (int u = 0; u < 2; u++) begin
      acc_n[u] = 0; load_cnt[u] = 0; sync_cnt[u] = 0;
      booting[u] = 1'b0; prev_load[u] = 1'b0;
    end
    #1;
    check_reset(0);
    check_reset(1);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back stream, then a host stall after five words.
    run_boot(0, 0, CW0);
    run_boot(0, 0, 5);
    pulse(0, 1'b0, 1'b1);
    check_idle(0, 11'd5, 1'b1);

    // Reload after the error, then halt out of RUN.
    run_boot(0, 0, CW0);
    pulse(0, 1'b0, 1'b1);
    check_idle(0, 11'(CW0), 1'b0);

    // Halt and start together: halt wins, a later start reboots.
    run_boot(0, 0, CW0);
    pulse(0, 1'b1, 1'b1);
    check_idle(0, 11'(CW0), 1'b0);
    run_boot(0, 0, CW0);

    // Random host pacing: some boots complete, some underrun.
    for (int i = 0; i < 24; i++) run_boot(0, $urandom_range(2, 0), CW0);

    // Boot shorter than the prefill level.
    run_boot(1, 0, CW1);
    for (int i = 0; i < 4; i++) run_boot(1, $urandom_range(3, 0), CW1);

    // Asynchronous reset in the middle of a LOAD burst.
    begin_boot(0);
    fork
      begin : drv
        bit ok2;
        ok2 = 1'b1;
        for (int j = 0; j < CW0 && ok2; j++) push_word(0, 16'($urandom), ok2);
      end
      begin : rst_mid
        int t;
        t = 0;
        while (word_cnt[0] != 11'd5 && t < 100) begin @(negedge clk); t++; end
        check("rst_reach5", word_cnt[0], 5);
        check("rst_in_load", cpu_rst[0], 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check_reset(0);
        check_reset(1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    booting[0] = 1'b0;
    @(posedge clk); #1;
    run_boot(0, 0, CW0);
    run_boot(1, 0, CW1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
